arb2to1_rr: RTL

Two-input round-robin arbiter with a registered output slice. It sits directly upstream of the 2-to-1 multiplexer stage. It accepts two valid/ready data streams (A and B) and grants one per cycle. It presents the winner on a single registered output stream and drives the mux select `sel` (0 = A, 1 = B), so the mux and the arbiter always agree on the source. Saturating per-source grant counters support bring-up and fairness checks.

---
 rtl/arb2to1_rr_pkg.sv | 5 +
 rtl/sat_counter.sv | 18 +
 rtl/arb2to1_rr.sv | 84 ++++++++
 3 files changed

// File: rtl/arb2to1_rr_pkg.sv
// arb2to1_rr_pkg: source-select constants shared by the arbiter and the downstream mux
package arb2to1_rr_pkg;
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (inc && cnt_q != '1)
            cnt_q <= cnt_q + CNT_W'(1);
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/arb2to1_rr.sv
// arb2to1_rr: two-input round-robin arbiter feeding a registered output slice
module arb2to1_rr
    import arb2to1_rr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             sel,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic             y_valid_q, y_valid_d;
    logic             sel_q, sel_d;
    logic             prio_q, prio_d;
    logic             load, grant_a, grant_b, accept, win;

    // rst_n gating keeps both readies low while the part is held in reset
    assign load    = ~y_valid_q | y_ready;
    assign grant_a = a_valid & (~b_valid | (prio_q == SRC_A));
    assign grant_b = b_valid & (~a_valid | (prio_q == SRC_B));
    assign a_ready = rst_n & load & grant_a;
    assign b_ready = rst_n & load & grant_b;
    assign accept  = (a_valid & a_ready) | (b_valid & b_ready);
    assign win     = b_ready ? SRC_B : SRC_A;

    always_comb begin
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        sel_d     = sel_q;
        prio_d    = prio_q;
        if (load) begin
            y_valid_d = accept;
            if (accept) begin
                y_data_d = (win == SRC_B) ? b_data : a_data;
                sel_d    = win;
                prio_d   = ~win;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            sel_q     <= SRC_A;
            prio_q    <= SRC_A;
        end else begin
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            sel_q     <= sel_d;
            prio_q    <= prio_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign sel     = sel_q;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (a_valid & a_ready),
        .cnt   (cnt_a)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (b_valid & b_ready),
        .cnt   (cnt_b)
    );
endmodule
